// File: rtl/alu_pkg.sv
// Shared opcode encoding and widths for the registered ALU.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB,
        OP_MUL,
        OP_DIV,
        OP_AND,
        OP_OR,
        OP_NOT,
        OP_SHL,
        OP_SHR
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational opcode decode and compute for alu_core; cout exists only when ALU_FLAGS_EN is defined.
module alu_comb
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [OP_W-1:0] op,
    output logic [N-1:0]    result
`ifdef ALU_FLAGS_EN
    ,
    output logic            cout
`endif
);

    // N always fits in N bits for N >= 2, so the shift limit compares at operand width.
    localparam logic [N-1:0] SHIFT_LIMIT = N'(N);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_DIV:  result = (b == '0) ? '1 : a / b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            OP_SHL:  result = (b >= SHIFT_LIMIT) ? '0 : a << b;
            OP_SHR:  result = (b >= SHIFT_LIMIT) ? '0 : a >> b;
            default: result = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        cout = 1'b0;
        case (op)
            // The truncated sum drops below a exactly when bit N-1 carried out.
            OP_ADD:  cout = (a + b) < a;
            OP_SUB:  cout = a < b;
            OP_MUL:  cout = (({{N{1'b0}}, a} * {{N{1'b0}}, b}) >> N) != '0;
            OP_DIV:  cout = (b == '0);
            default: cout = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_core.sv
// Registered N-bit ALU: one-cycle latency, no backpressure.
// Optional cout/zero flag ports are enabled by defining ALU_FLAGS_EN.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [OP_W-1:0] operation,
    output logic            out_valid,
    output logic [N-1:0]    result
`ifdef ALU_FLAGS_EN
    ,
    output logic            cout,
    output logic            zero
`endif
);

    logic [N-1:0] result_next;
    logic [N-1:0] result_reg;
    logic         valid_reg;
`ifdef ALU_FLAGS_EN
    logic         cout_next;
    logic         cout_reg;
    logic         zero_reg;
`endif

    alu_comb #(.N(N)) u_comb (
        .a      (a),
        .b      (b),
        .op     (operation),
        .result (result_next)
`ifdef ALU_FLAGS_EN
        ,
        .cout   (cout_next)
`endif
    );

    // Result only updates on an accepted request; otherwise it holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                result_reg <= result_next;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cout_reg <= 1'b0;
            zero_reg <= 1'b0;
        end else if (in_valid) begin
            cout_reg <= cout_next;
            zero_reg <= (result_next == '0);
        end
    end

    assign cout = cout_reg;
    assign zero = zero_reg;
`endif

    assign out_valid = valid_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: driver queues expectations, monitor checks one cycle later.
module tb_alu_core;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   operation;
    logic         out_valid;
    logic [N-1:0] result;
`ifdef ALU_FLAGS_EN
    logic         cout;
    logic         zero;
`endif

    alu_core #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .operation (operation),
        .out_valid (out_valid),
        .result    (result)
`ifdef ALU_FLAGS_EN
        ,
        .cout      (cout),
        .zero      (zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           valid;
        logic [N-1:0] result;
        bit           cout;
        bit           zero;
        int           id;
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   txn_id   = 0;

    logic [N-1:0] model_result = '0;
    bit           model_cout   = 1'b0;
    bit           model_zero   = 1'b0;

    int sweep1 [9] = '{'h12, 'h0C, 'h2D, 'h05, 'h03, 'h0F, 'hF0, 'h78, 'h01};
    int sweep2 [9] = '{'hFF, 'hE1, 'h10, 'h10, 'h00, 'hFF, 'h0F, 'h00, 'h00};

    // Reference ALU in plain integer arithmetic.
    function automatic void ref_alu(input int unsigned op, input int unsigned ai,
                                    input int unsigned bi, output logic [N-1:0] res,
                                    output bit c);
        int unsigned mask;
        int unsigned r;
        mask = (32'd1 << N) - 32'd1;
        r = 0;
        c = 1'b0;
        case (op)
            0: begin r = ai + bi; c = (r > mask); end
            1: begin r = ai - bi; c = (ai < bi); end
            2: begin r = ai * bi; c = (r > mask); end
            3: begin r = (bi == 0) ? mask : ai / bi; c = (bi == 0); end
            4: r = ai & bi;
            5: r = ai | bi;
            6: r = ~ai;
            7: r = (bi >= N) ? 0 : ai << bi;
            8: r = (bi >= N) ? 0 : ai >> bi;
            default: r = 0;
        endcase
        r = r & mask;
        res = r[N-1:0];
    endfunction

    function automatic void check(input string name, input int id,
                                  input logic [N-1:0] act, input logic [N-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s txn %0d: got 0x%0h, expected 0x%0h", name, id, act, req);
    endfunction

    task automatic send(input bit rn, input bit v, input logic [3:0] op,
                        input logic [N-1:0] av, input logic [N-1:0] bv, input int lit = -1);
        exp_t         e;
        logic [N-1:0] r;
        bit           c;
        @(negedge clk);
        rst_n     = rn;
        in_valid  = v;
        operation = op;
        a         = av;
        b         = bv;
        if (!rn) begin
            model_result = '0;
            model_cout   = 1'b0;
            model_zero   = 1'b0;
        end else if (v) begin
            ref_alu(int'(op), int'(av), int'(bv), r, c);
            if (lit >= 0) r = lit[N-1:0];
            model_result = r;
            model_cout   = c;
            model_zero   = (r == '0);
        end
        e.valid  = rn && v;
        e.result = model_result;
        e.cout   = model_cout;
        e.zero   = model_zero;
        e.id     = txn_id;
        e.op     = op;
        e.a      = av;
        e.b      = bv;
        txn_id++;
        exp_q.push_back(e);
    endtask

    // Monitor: each expectation pushed at a falling edge is due just after the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", e.id, N'(out_valid), N'(e.valid));
                check("result", e.id, result, e.result);
`ifdef ALU_FLAGS_EN
                check("cout", e.id, N'(cout), N'(e.cout));
                check("zero", e.id, N'(zero), N'(e.zero));
`endif
                $display("txn %0d op=%0d a=0x%02h b=0x%02h out_valid=%0b result=0x%02h exp_valid=%0b exp_result=0x%02h",
                         e.id, e.op, e.a, e.b, out_valid, result, e.valid, e.result);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit           rn_r;
        bit           v_r;
        logic [3:0]   op_r;
        logic [N-1:0] a_r;
        logic [N-1:0] b_r;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        operation = '0;
        a         = '0;
        b         = '0;

        // Reset held with in_valid asserted
        send(1'b0, 1'b1, 4'd0, 8'h0F, 8'h03);
        send(1'b0, 1'b1, 4'd2, 8'h0F, 8'h03);

        for (int k = 0; k < 9; k++) send(1'b1, 1'b1, 4'(k), 8'h0F, 8'h03, sweep1[k]);
        for (int k = 0; k < 9; k++) send(1'b1, 1'b1, 4'(k), 8'hF0, 8'h0F, sweep2[k]);

        // Edge cases
        send(1'b1, 1'b1, 4'd0, 8'hFF, 8'h01, 'h00);
        send(1'b1, 1'b1, 4'd1, 8'h03, 8'h05, 'hFE);
        send(1'b1, 1'b1, 4'd3, 8'h55, 8'h00, 'hFF);
        send(1'b1, 1'b1, 4'hC, 8'h5A, 8'h33, 'h00);
        send(1'b1, 1'b1, 4'd7, 8'h81, 8'h08, 'h00);
        send(1'b1, 1'b1, 4'd8, 8'h81, 8'h07, 'h01);

        // Back-to-back then hold
        send(1'b1, 1'b1, 4'd2, 8'h13, 8'h11);
        send(1'b1, 1'b1, 4'd5, 8'hA0, 8'h05);
        send(1'b1, 1'b1, 4'd1, 8'h10, 8'h20);
        send(1'b1, 1'b0, 4'd0, 8'h77, 8'h77);
        send(1'b1, 1'b0, 4'd4, 8'h00, 8'h00);

        // Reset mid-stream
        send(1'b1, 1'b1, 4'd0, 8'h40, 8'h02);
        send(1'b0, 1'b1, 4'd5, 8'h3C, 8'hC3);
        send(1'b1, 1'b0, 4'd5, 8'h3C, 8'hC3);
        send(1'b1, 1'b1, 4'd6, 8'h3C, 8'h00);

        for (int i = 0; i < 300; i++) begin
            rn_r = ($urandom_range(0, 49) != 0);
            v_r  = ($urandom_range(0, 9) < 8);
            op_r = 4'($urandom_range(0, 15));
            a_r  = N'($urandom);
            b_r  = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 9));
            send(rn_r, v_r, op_r, a_r, b_r);
        end

        send(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
        repeat (4) @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
